// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: prescaled step ticks drive fill-bounce, chase, ping-pong and binary patterns.
// Optional PWM dimming (BRIGHT port) is built when LED_PWM_DIM_EN is defined.
module led_pattern_seq #(
    parameter int N_LEDS   = 4,
    parameter int TICK_DIV = 25000000
) (
    input  logic              FPGA_CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic [1:0]        SPEED,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]        BRIGHT,
`endif
    output logic [N_LEDS-1:0] LED,
    output logic              STEP_PULSE
);

    localparam int IW = N_LEDS;

    typedef enum logic [1:0] {
        M_FILL  = 2'd0,
        M_CHASE = 2'd1,
        M_PING  = 2'd2,
        M_BIN   = 2'd3
    } mode_t;

    mode_t             mode_q;
    logic [25:0]       pcnt;
    logic [25:0]       period;
    logic              tick;
    logic              chg;
    logic              tick_d;
    logic              load;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     last_idx;
    logic [N_LEDS-1:0] pat;
    logic [N_LEDS-1:0] led_q;
    int                k;
    int                fill;
    int                dot;

    assign period = 26'(TICK_DIV) >> SPEED;
    // ">=" rather than "==" so a shrinking period fires at once instead of wrapping
    assign tick   = EN && (pcnt >= period - 26'd1);
    assign chg    = (MODE != mode_q);

    always_comb begin
        pat      = '0;
        last_idx = '0;
        k        = int'(idx);
        fill     = 0;
        dot      = 0;
        case (mode_q)
            M_FILL: begin
                last_idx = IW'(2*N_LEDS - 1);
                fill     = (k <= N_LEDS) ? k : 2*N_LEDS - k;
                for (int i = 0; i < N_LEDS; i++) pat[i] = (i < fill);
            end
            M_CHASE: begin
                last_idx = IW'(N_LEDS - 1);
                for (int i = 0; i < N_LEDS; i++) pat[i] = (i == k);
            end
            M_PING: begin
                last_idx = IW'(2*N_LEDS - 3);
                dot      = (k < N_LEDS) ? k : 2*N_LEDS - 2 - k;
                for (int i = 0; i < N_LEDS; i++) pat[i] = (i == dot);
            end
            M_BIN: begin
                last_idx = '1;
                pat      = idx;
            end
            default: ;
        endcase
    end

    // tick_d holds a step whose LED update is still owed while EN is low,
    // so LED and STEP_PULSE always move together.
    always_ff @(posedge FPGA_CLK) begin
        if (RST) begin
            mode_q     <= M_FILL;
            pcnt       <= '0;
            idx        <= '0;
            tick_d     <= 1'b0;
            load       <= 1'b1;
            led_q      <= '0;
            STEP_PULSE <= 1'b0;
        end else begin
            mode_q     <= mode_t'(MODE);
            STEP_PULSE <= EN & tick_d;
            load       <= chg;
            if (EN || load) led_q <= pat;
            if (chg) begin
                pcnt   <= '0;
                idx    <= '0;
                tick_d <= 1'b0;
            end else if (EN) begin
                tick_d <= tick;
                if (tick) begin
                    pcnt <= '0;
                    idx  <= (idx == last_idx) ? '0 : idx + 1'b1;
                end else begin
                    pcnt <= pcnt + 26'd1;
                end
            end
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge FPGA_CLK) begin
        if (RST) pwm_cnt <= '0;
        else     pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
    end

    assign LED = led_q & {N_LEDS{pwm_cnt < BRIGHT}};
`else
    assign LED = led_q;
`endif

endmodule
